// File: rtl/test_mailbox.sv
// Memory-mapped test mailbox: pass/fail result, done flag, cycle counter, general registers.
// Optional watchdog compiled in with `define TEST_MAILBOX_TIMEOUT_EN.
module test_mailbox #(
   parameter logic [31:0] BASE_ADDR      = 32'h04000100,
   parameter int          N_REGS         = 4,
   parameter int          WAIT_STATES    = 0,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        req_i,
   input  logic        wren_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        done_o,
   output logic [31:0] data_o,
   output logic        flag_done_o,
   output logic        flag_pass_o,
   output logic        flag_timeout_o,
   output logic [31:0] result_o,
   output logic [31:0] cycle_count_o
);

   localparam int          WIN_BYTES = 16 + 4 * N_REGS;
   localparam int          MB_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [31:0] TIMEOUT_RESULT = 32'hDEAD0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        accept;

   logic [31:0] offset;
   logic        in_window;
   logic [6:0]  word_idx;
   logic        is_mbox;
   logic [MB_W-1:0] mb_sel;

   logic [31:0] scratch;
   logic [31:0] mbox [N_REGS];
   logic [31:0] rd_mux;
   logic [31:0] rdata_q;
   logic [3:0]  wait_cnt;

   logic        wr_en;
   logic        result_wr;
   logic        timeout_hit;

   // Word-aligned offset; addresses below the base wrap to huge values and fall outside.
   assign offset    = (addr_i & 32'hFFFF_FFFC) - (BASE_ADDR & 32'hFFFF_FFFC);
   assign in_window = (offset < 32'(WIN_BYTES));
   assign word_idx  = offset[8:2];
   assign is_mbox   = (word_idx >= 7'd4);
   assign mb_sel    = MB_W'(word_idx - 7'd4);

   assign wr_en     = accept && wren_i;
   assign result_wr = wr_en && (word_idx == 7'd1) && (data_i != 32'd0) && !flag_done_o;

   // ---------------------------------------------------------------------
   // Response FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done_o     = 1'b0;
      data_o     = 32'd0;
      case (state)
         ST_IDLE: begin
            if (req_i && in_window) begin
               accept     = 1'b1;
               state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            done_o     = 1'b1;
            data_o     = rdata_q;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wait_cnt <= 4'd0;
      end else if (accept) begin
         wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Read path: sampled at the accepting edge, before any write lands
   // ---------------------------------------------------------------------
   always_comb begin
      rd_mux = 32'd0;
      case (word_idx)
         7'd0: rd_mux = scratch;
         7'd1: rd_mux = result_o;
         7'd2: rd_mux = cycle_count_o;
         7'd3: rd_mux = {29'd0, flag_timeout_o, flag_pass_o, flag_done_o};
         default: begin
            if (is_mbox) begin
               rd_mux = mbox[mb_sel];
            end
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         rdata_q <= 32'd0;
      end else if (accept) begin
         rdata_q <= wren_i ? 32'd0 : rd_mux;
      end
   end

   // ---------------------------------------------------------------------
   // Writable registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         scratch <= 32'd0;
      end else if (wr_en && word_idx == 7'd0) begin
         scratch <= data_i;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < N_REGS; i++) begin
            mbox[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < N_REGS; i++) begin
            if (wr_en && is_mbox && mb_sel == MB_W'(i)) begin
               mbox[i] <= data_i;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Cycle counter: runs until done, saturating
   // ---------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         cycle_count_o <= 32'd0;
      end else if (!flag_done_o && cycle_count_o != 32'hFFFF_FFFF) begin
         cycle_count_o <= cycle_count_o + 32'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------
`ifdef TEST_MAILBOX_TIMEOUT_EN
   // A RESULT write on the same edge takes priority over the watchdog.
   assign timeout_hit = !flag_done_o && (cycle_count_o == TIMEOUT_CYCLES) && !result_wr;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         flag_timeout_o <= 1'b0;
      end else if (timeout_hit) begin
         flag_timeout_o <= 1'b1;
      end
   end
`else
   assign timeout_hit    = 1'b0;
   assign flag_timeout_o = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Result and run flags: first nonzero RESULT write or watchdog wins
   // ---------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         result_o    <= 32'd0;
         flag_done_o <= 1'b0;
         flag_pass_o <= 1'b0;
      end else if (result_wr) begin
         result_o    <= data_i;
         flag_done_o <= 1'b1;
         flag_pass_o <= (data_i == 32'h1);
      end else if (timeout_hit) begin
         result_o    <= TIMEOUT_RESULT;
         flag_done_o <= 1'b1;
      end
   end

endmodule
